vga_fb_arbiter: RTL

Shares one single-port synchronous frame-buffer RAM between three users, in strict priority order:
- display scan-out, driven by the VGA timing generator's x/y/blank;
- a host read/write port with a req/ack handshake;
- a frame-clear engine.

It sits between the timing generator and the video RAM and outputs the 4-bit pixel for the current x/y. Frame: 640x480, 4 bpp, 16-bit RAM words of 4 pixels, 160 words per line, 76800 words total.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_clear_engine.sv | 66 ++++++
 rtl/vga_fb_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and clear-engine state type for the 640x480x4bpp frame-buffer arbiter.
package vga_pkg;

  localparam int unsigned LINE_WORDS    = 160;
  localparam int unsigned VISIBLE_LINES = 480;
  localparam int unsigned FRAME_WORDS   = 76800;
  localparam int unsigned H_VISIBLE     = 640;

  // Display fetch window: word k+1 is read at x = 4k for k = -1..158
  localparam int DISP_X_MIN = -4;
  localparam int DISP_X_MAX = 632;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/vga_clear_engine.sv
// Frame-clear engine: walks the whole frame writing one colour, one word per granted cycle.
module vga_clear_engine
  import vga_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [PIX_W-1:0]  i_color,
  input  logic              i_grant,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [WORD_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [PIX_W-1:0]  r_color;
  logic              r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CLR_IDLE: begin
          if (i_start) begin
            r_state <= CLR_CLEAR;
            r_cnt   <= '0;
            r_color <= i_color;
          end
        end
        CLR_CLEAR: begin
          // Counter only advances on cycles the arbiter actually hands over
          if (i_grant) begin
            if (r_cnt == LAST_ADDR) begin
              r_state <= CLR_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= CLR_IDLE;
      endcase
    end
  end

  assign o_req   = (r_state == CLR_CLEAR);
  assign o_addr  = r_cnt;
  assign o_wdata = {(WORD_W / PIX_W){r_color}};
  assign o_busy  = (r_state == CLR_CLEAR);
  assign o_done  = r_done;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out > host port > frame clear,
// plus the prefetch/hold pixel path feeding PIX with zero latency relative to x.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic signed [10:0]  x,
  input  logic        [9:0]   y,
  input  logic                blank,
  output logic [PIX_W-1:0]    PIX,
  output logic [ADDR_W-1:0]   RAM_ADDR,
  output logic                RAM_WE,
  output logic [WORD_W-1:0]   RAM_WDATA,
  input  logic [WORD_W-1:0]   RAM_RDATA,
  input  logic                HREQ,
  input  logic                HWE,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [WORD_W-1:0]   HWDATA,
  output logic                HACK,
  output logic [WORD_W-1:0]   HRDATA,
  output logic                HRVALID,
  input  logic                CLR_START,
  input  logic [PIX_W-1:0]    CLR_COLOR,
  output logic                CLR_BUSY,
  output logic                CLR_DONE
);

  localparam logic signed [10:0] X_MIN   = 11'(DISP_X_MIN);
  localparam logic signed [10:0] X_MAX   = 11'(DISP_X_MAX);
  localparam logic signed [10:0] X_END   = 11'(H_VISIBLE);
  localparam logic        [9:0]  Y_LINES = 10'(VISIBLE_LINES);

  logic                w_vis_line;
  logic                w_slot;
  logic signed [10:0]  w_k;
  logic [ADDR_W-1:0]   w_k_ext;
  logic [ADDR_W-1:0]   w_y_ext;
  logic [ADDR_W-1:0]   w_disp_addr;
  logic                w_host_gnt;
  logic                w_clr_req;
  logic                w_clr_gnt;
  logic [ADDR_W-1:0]   w_clr_addr;
  logic [WORD_W-1:0]   w_clr_wdata;
  logic                w_pix_on;

  logic                r_disp_d;
  logic [WORD_W-1:0]   r_pref;
  logic [WORD_W-1:0]   r_hold;
  logic                r_hrvalid;
  logic [WORD_W-1:0]   r_hrdata;

  assign w_vis_line = (y < Y_LINES);
  assign w_slot     = w_vis_line && (x >= X_MIN) && (x <= X_MAX) && (x[1:0] == 2'b00);

  // x>>>2 is -1 at x=-4; sign-extension wraps y*160-1+1 back onto the line's word 0
  assign w_k         = x >>> 2;
  assign w_k_ext     = ADDR_W'(w_k);
  assign w_y_ext     = ADDR_W'(y);
  assign w_disp_addr = (w_y_ext << 7) + (w_y_ext << 5) + w_k_ext + ADDR_W'(1);

  assign w_host_gnt = ~RST & ~w_slot & HREQ;
  assign w_clr_gnt  = ~RST & ~w_slot & ~HREQ & w_clr_req;

  vga_clear_engine #(
    .PIX_W  (PIX_W),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (CLR_START),
    .i_color (CLR_COLOR),
    .i_grant (w_clr_gnt),
    .o_req   (w_clr_req),
    .o_addr  (w_clr_addr),
    .o_wdata (w_clr_wdata),
    .o_busy  (CLR_BUSY),
    .o_done  (CLR_DONE)
  );

  always_comb begin
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    if (w_slot) begin
      RAM_ADDR = w_disp_addr;
    end else if (w_host_gnt) begin
      RAM_ADDR  = HADDR;
      RAM_WE    = HWE;
      RAM_WDATA = HWDATA;
    end else if (w_clr_gnt) begin
      RAM_ADDR  = w_clr_addr;
      RAM_WE    = 1'b1;
      RAM_WDATA = w_clr_wdata;
    end
  end

  assign HACK = w_host_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp_d  <= 1'b0;
      r_pref    <= '0;
      r_hold    <= '0;
      r_hrvalid <= 1'b0;
      r_hrdata  <= '0;
    end else begin
      r_disp_d <= w_slot;
      if (r_disp_d) r_pref <= RAM_RDATA;
      if ((x[1:0] == 2'b11) && w_vis_line) r_hold <= r_pref;
      r_hrvalid <= w_host_gnt & ~HWE;
      if (r_hrvalid) r_hrdata <= RAM_RDATA;
    end
  end

  // Read data is passed straight through in the valid cycle, then held
  assign HRDATA  = r_hrvalid ? RAM_RDATA : r_hrdata;
  assign HRVALID = r_hrvalid;

  assign w_pix_on = ~blank & ~x[10] & (x < X_END);

  always_comb begin
    PIX = '0;
    if (w_pix_on) PIX = r_hold[x[1:0]*PIX_W +: PIX_W];
  end

endmodule
